fcvt_pipe: RTL and testbench

Pipelined, parametrised int<->single-float conversion unit. It replaces the combinational itof/ftoi helper chain in the FPU. One unit handles both directions, selected per operation by a mode bit. Every input carries a tag through the pipeline, and a valid/ready handshake on both sides lets the FPU issue stage stall it.

---
 rtl/fcvt_pipe.sv | 183 ++++++++++++++++++
 tb/tb_fcvt_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fcvt_pipe.sv
// Three-stage pipelined int<->IEEE-754 single converter with tag passthrough.
// Stages: S1 decode, S2 normalise, S3 round/pack; all stages advance together.
module fcvt_pipe #(
  parameter int INT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf
);

  localparam int          LW      = $clog2(INT_W);
  localparam logic [33:0] LIM     = 34'd1 << (INT_W - 1);
  localparam logic [31:0] POS_MAX = 32'(LIM - 34'd1);
  localparam logic [31:0] NEG_MIN = 32'(34'd0 - LIM);
  localparam logic [7:0]  BIG_EXP = 8'(127 + INT_W);

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- S1 decode ----------------
  logic [INT_W-1:0] s1_x;
  logic [INT_W-1:0] s1_mag_next;
  logic [LW-1:0]    s1_lead_next;
  logic             s1_sign_next, s1_zero_next, s1_nan_next, s1_big_next;

  logic             s1_valid_reg, s1_mode_reg, s1_sign_reg, s1_zero_reg, s1_nan_reg, s1_big_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic [INT_W-1:0] s1_mag_reg;
  logic [LW-1:0]    s1_lead_reg;
  logic [7:0]       s1_exp_reg;
  logic [22:0]      s1_man_reg;

  always_comb begin
    s1_x = in_data[INT_W-1:0];
    // Unsigned INT_W-bit magnitude holds 2^(INT_W-1) for the most negative input.
    s1_mag_next = s1_x[INT_W-1] ? -s1_x : s1_x;
    s1_lead_next = '0;
    for (int i = 0; i < INT_W; i++) begin
      if (s1_mag_next[i]) s1_lead_next = LW'(i);
    end
    s1_sign_next = in_mode ? in_data[31] : s1_x[INT_W-1];
    s1_nan_next  = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
    s1_big_next  = (in_data[30:23] >= BIG_EXP) && !s1_nan_next;
    // Denormals (exp 0) fall under |x| < 0.5 and flush to zero.
    s1_zero_next = in_mode ? (in_data[30:23] < 8'd126) : (s1_x == '0);
  end

  // ---------------- S2 normalise ----------------
  logic [30:0] s2_norm;
  logic [5:0]  s2_fsh;
  logic [33:0] s2_ih;

  logic             s2_valid_reg, s2_mode_reg, s2_sign_reg, s2_zero_reg, s2_nan_reg, s2_big_reg;
  logic [TAG_W-1:0] s2_tag_reg;
  logic [22:0]      s2_frac_reg;
  logic             s2_guard_reg, s2_sticky_reg;
  logic [7:0]       s2_exp_reg;
  logic [32:0]      s2_int_reg;
  logic             s2_half_reg;

  always_comb begin
    // Leading one moved to bit 31; the hidden bit is dropped by the 31-bit truncation.
    s2_norm = 31'(32'(s1_mag_reg) << (5'd31 - 5'(s1_lead_reg)));
    // Shift by exp-126 so the binary point lands between bit 24 and bit 23 of {1,man}.
    s2_fsh  = 6'(s1_exp_reg - 8'd126);
    s2_ih   = 34'(({33'd0, 1'b1, s1_man_reg} << s2_fsh) >> 23);
  end

  // ---------------- S3 round / pack ----------------
  logic        s3_rup;
  logic [23:0] s3_frac_r;
  logic [7:0]  s3_exp_r;
  logic [33:0] s3_mag;
  logic        s3_sat;
  logic [31:0] s3_data_next;
  logic        s3_ovf_next;

  always_comb begin
    s3_rup    = s2_guard_reg & (s2_sticky_reg | s2_frac_reg[0]);
    s3_frac_r = {1'b0, s2_frac_reg} + {23'd0, s3_rup};
    s3_exp_r  = s2_exp_reg + {7'd0, s3_frac_r[23]};
    s3_mag    = {1'b0, s2_int_reg} + {33'd0, s2_half_reg};
    s3_sat    = s2_big_reg || (s2_sign_reg ? (s3_mag > LIM) : (s3_mag > LIM - 34'd1));
    s3_data_next = '0;
    s3_ovf_next  = 1'b0;
    if (!s2_mode_reg) begin
      if (!s2_zero_reg) s3_data_next = {s2_sign_reg, s3_exp_r, s3_frac_r[22:0]};
    end else if (!s2_zero_reg) begin
      if (s2_nan_reg) begin
        s3_data_next = POS_MAX;
        s3_ovf_next  = 1'b1;
      end else if (s3_sat) begin
        s3_data_next = s2_sign_reg ? NEG_MIN : POS_MAX;
        s3_ovf_next  = 1'b1;
      end else begin
        s3_data_next = s2_sign_reg ? 32'(~s3_mag + 34'd1) : s3_mag[31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      out_valid     <= 1'b0;
      s1_mode_reg   <= 1'b0;
      s1_sign_reg   <= 1'b0;
      s1_zero_reg   <= 1'b0;
      s1_nan_reg    <= 1'b0;
      s1_big_reg    <= 1'b0;
      s1_tag_reg    <= '0;
      s1_mag_reg    <= '0;
      s1_lead_reg   <= '0;
      s1_exp_reg    <= '0;
      s1_man_reg    <= '0;
      s2_mode_reg   <= 1'b0;
      s2_sign_reg   <= 1'b0;
      s2_zero_reg   <= 1'b0;
      s2_nan_reg    <= 1'b0;
      s2_big_reg    <= 1'b0;
      s2_tag_reg    <= '0;
      s2_frac_reg   <= '0;
      s2_guard_reg  <= 1'b0;
      s2_sticky_reg <= 1'b0;
      s2_exp_reg    <= '0;
      s2_int_reg    <= '0;
      s2_half_reg   <= 1'b0;
      out_data      <= '0;
      out_tag       <= '0;
      out_ovf       <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid_reg <= 1'b0;
        s2_valid_reg <= 1'b0;
        out_valid    <= 1'b0;
      end else if (adv) begin
        s1_valid_reg <= in_valid;
        s2_valid_reg <= s1_valid_reg;
        out_valid    <= s2_valid_reg;
      end
      if (adv) begin
        s1_mode_reg   <= in_mode;
        s1_sign_reg   <= s1_sign_next;
        s1_zero_reg   <= s1_zero_next;
        s1_nan_reg    <= s1_nan_next;
        s1_big_reg    <= s1_big_next;
        s1_tag_reg    <= in_tag;
        s1_mag_reg    <= s1_mag_next;
        s1_lead_reg   <= s1_lead_next;
        s1_exp_reg    <= in_data[30:23];
        s1_man_reg    <= in_data[22:0];
        s2_mode_reg   <= s1_mode_reg;
        s2_sign_reg   <= s1_sign_reg;
        s2_zero_reg   <= s1_zero_reg;
        s2_nan_reg    <= s1_nan_reg;
        s2_big_reg    <= s1_big_reg;
        s2_tag_reg    <= s1_tag_reg;
        s2_frac_reg   <= s2_norm[30:8];
        s2_guard_reg  <= s2_norm[7];
        s2_sticky_reg <= |s2_norm[6:0];
        s2_exp_reg    <= 8'd127 + 8'(s1_lead_reg);
        s2_int_reg    <= s2_ih[33:1];
        s2_half_reg   <= s2_ih[0];
        out_data      <= s3_data_next;
        out_tag       <= s2_tag_reg;
        out_ovf       <= s3_ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_fcvt_pipe.sv
// Directed bench for fcvt_pipe: INT_W=32 and INT_W=16 instances share one input stream.
module tb_fcvt_pipe;

  logic        clk, rstn, in_valid, in_mode, flush, out_ready;
  logic [31:0] in_data;
  logic [4:0]  in_tag;

  logic        rdy32, v32, ovf32, rdy16, v16, ovf16;
  logic [31:0] d32, d16;
  logic [4:0]  t32, t16;

  int checks = 0;
  int failures = 0;

  logic [31:0] bp_exp [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000};

  fcvt_pipe #(.INT_W(32), .TAG_W(5)) u_dut32 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy32), .in_mode(in_mode),
    .in_data(in_data), .in_tag(in_tag), .flush(flush), .out_valid(v32), .out_ready(out_ready),
    .out_data(d32), .out_tag(t32), .out_ovf(ovf32)
  );

  fcvt_pipe #(.INT_W(16), .TAG_W(5)) u_dut16 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy16), .in_mode(in_mode),
    .in_data(in_data), .in_tag(in_tag), .flush(flush), .out_valid(v16), .out_ready(out_ready),
    .out_data(d16), .out_tag(t16), .out_ovf(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  // One isolated operation: checks acceptance, 3-cycle latency and both instances' results.
  task automatic run_op(input string name, input logic mode, input logic [31:0] data,
                        input logic [4:0] tag, input logic [31:0] e32, input logic eo32,
                        input logic [31:0] e16, input logic eo16);
    int cnt;
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    in_tag   = tag;
    #1;
    chk({name, "/in_ready"}, 32'(rdy32), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 1;
    while (!v32 && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    chk({name, "/latency"}, 32'(cnt), 32'd3);
    chk({name, "/data32"}, d32, e32);
    chk({name, "/ovf32"}, 32'(ovf32), 32'(eo32));
    chk({name, "/tag32"}, 32'(t32), 32'(tag));
    chk({name, "/valid16"}, 32'(v16), 32'd1);
    chk({name, "/data16"}, d16, e16);
    chk({name, "/ovf16"}, 32'(ovf16), 32'(eo16));
    chk({name, "/tag16"}, 32'(t16), 32'(tag));
  endtask

  initial begin
    int tx, rx, bad;
    logic stalled;
    logic [31:0] hold_d;
    logic [4:0]  hold_t;

    rstn = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst/out_valid", 32'(v32), 32'd0);
    chk("rst/out_data", d32, 32'd0);
    chk("rst/out_tag", 32'(t32), 32'd0);
    chk("rst/out_ovf", 32'(ovf32), 32'd0);
    chk("rst/in_ready", 32'(rdy32), 32'd1);
    chk("rst/out_valid16", 32'(v16), 32'd0);
    rstn = 1'b1;

    run_op("itof_1",      1'b0, 32'h00000001, 5'd3,  32'h3F800000, 1'b0, 32'h3F800000, 1'b0);
    run_op("itof_min",    1'b0, 32'h80000000, 5'd4,  32'hCF000000, 1'b0, 32'h00000000, 1'b0);
    run_op("itof_zero",   1'b0, 32'h00000000, 5'd5,  32'h00000000, 1'b0, 32'h00000000, 1'b0);
    run_op("itof_tie",    1'b0, 32'h01000001, 5'd6,  32'h4B800000, 1'b0, 32'h3F800000, 1'b0);
    run_op("itof_rup",    1'b0, 32'h01000003, 5'd7,  32'h4B800002, 1'b0, 32'h40400000, 1'b0);
    run_op("itof_carry",  1'b0, 32'h7FFFFFFF, 5'd8,  32'h4F000000, 1'b0, 32'hBF800000, 1'b0);
    run_op("itof_8000",   1'b0, 32'h00008000, 5'd9,  32'h47000000, 1'b0, 32'hC7000000, 1'b0);
    run_op("itof_hibits", 1'b0, 32'hABCD0001, 5'd10, 32'hCEA86600, 1'b0, 32'h3F800000, 1'b0);
    run_op("ftoi_2p5",    1'b1, 32'h40200000, 5'd11, 32'h00000003, 1'b0, 32'h00000003, 1'b0);
    run_op("ftoi_m2p5",   1'b1, 32'hC0200000, 5'd12, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFD, 1'b0);
    run_op("ftoi_lthalf", 1'b1, 32'h3EFFFFFF, 5'd13, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
    run_op("ftoi_half",   1'b1, 32'h3F000000, 5'd14, 32'h00000001, 1'b0, 32'h00000001, 1'b0);
    run_op("ftoi_1p5",    1'b1, 32'h3FC00000, 5'd15, 32'h00000002, 1'b0, 32'h00000002, 1'b0);
    run_op("ftoi_m1p5",   1'b1, 32'hBFC00000, 5'd16, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFE, 1'b0);
    run_op("ftoi_2p31",   1'b1, 32'h4F000000, 5'd17, 32'h7FFFFFFF, 1'b1, 32'h00007FFF, 1'b1);
    run_op("ftoi_m2p31",  1'b1, 32'hCF000000, 5'd18, 32'h80000000, 1'b0, 32'hFFFF8000, 1'b1);
    run_op("ftoi_nan",    1'b1, 32'h7FC00000, 5'd19, 32'h7FFFFFFF, 1'b1, 32'h00007FFF, 1'b1);
    run_op("ftoi_2p15",   1'b1, 32'h47000000, 5'd20, 32'h00008000, 1'b0, 32'h00007FFF, 1'b1);
    run_op("ftoi_m2p15",  1'b1, 32'hC7000000, 5'd21, 32'hFFFF8000, 1'b0, 32'hFFFF8000, 1'b0);
    run_op("ftoi_ninf",   1'b1, 32'hFF800000, 5'd22, 32'h80000000, 1'b1, 32'hFFFF8000, 1'b1);
    run_op("ftoi_denorm", 1'b1, 32'h80400000, 5'd23, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
    run_op("ftoi_near31", 1'b1, 32'h4EFFFFFF, 5'd24, 32'h7FFFFF80, 1'b0, 32'h00007FFF, 1'b1);

    // Back-pressure: six back-to-back itof ops, consumer stalls cycles 3..7.
    tx = 0; rx = 0; stalled = 1'b0; hold_d = '0; hold_t = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        chk("bp/hold_valid", 32'(v32), 32'd1);
        chk("bp/hold_data", d32, hold_d);
        chk("bp/hold_tag", 32'(t32), 32'(hold_t));
      end
      out_ready = !(cyc >= 3 && cyc <= 7);
      #1;
      stalled = 1'b0;
      if (v32 && !out_ready) begin
        chk("bp/in_ready_low", 32'(rdy32), 32'd0);
        stalled = 1'b1;
        hold_d  = d32;
        hold_t  = t32;
      end
      if (v32 && out_ready) begin
        chk("bp/no_extra", 32'(rx < 6), 32'd1);
        if (rx < 6) begin
          chk("bp/data", d32, bp_exp[rx]);
          chk("bp/tag", 32'(t32), 32'(16 + rx));
        end
        rx++;
      end
      if (tx < 6) begin
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_data  = 32'(tx + 1);
        in_tag   = 5'(16 + tx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && rdy32) tx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp/sent", 32'(tx), 32'd6);
    chk("bp/received", 32'(rx), 32'd6);

    // Flush on the cycle the third op is presented: nothing may emerge.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_mode  = 1'b0;
      in_data  = 32'(k + 1);
      in_tag   = 5'(1 + k);
      flush    = (k == 2);
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (v32 || v16) bad++;
      @(negedge clk);
    end
    chk("flush/no_out_valid", 32'(bad), 32'd0);
    run_op("post_flush", 1'b0, 32'h00000002, 5'd25, 32'h40000000, 1'b0, 32'h40000000, 1'b0);

    // Async reset with a stalled result on the output and more ops in flight.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_mode  = 1'b0;
      in_data  = 32'(k + 1);
      in_tag   = 5'(7 + k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rstmid/pre_valid", 32'(v32), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    chk("rstmid/out_valid", 32'(v32), 32'd0);
    chk("rstmid/out_data", d32, 32'd0);
    chk("rstmid/out_tag", 32'(t32), 32'd0);
    chk("rstmid/out_ovf", 32'(ovf32), 32'd0);
    chk("rstmid/in_ready", 32'(rdy32), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (v32 || v16) bad++;
    end
    chk("rstmid/no_stale", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
